stage_ex: RTL and testbench

STAGE_EX -- requirements
Module: stage_ex

---
 rtl/stage_ex_pkg.sv | 36 +++
 rtl/stage_ex_if.sv | 25 ++
 rtl/stage_ex_divu_iter.sv | 93 +++++++++
 rtl/stage_ex.sv | 122 ++++++++++++
 tb/tb_stage_ex.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/stage_ex_pkg.sv
// Shared CPU definitions: operation and result-class encodings used by decode and execute,
// plus the divider state type.
package stage_ex_pkg;

  localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
  localparam logic [7:0] EXE_ADDU_OP = 8'b00100001;
  localparam logic [7:0] EXE_SUBU_OP = 8'b00100011;
  localparam logic [7:0] EXE_SLT_OP  = 8'b00101010;
  localparam logic [7:0] EXE_MFHI_OP = 8'b00010000;
  localparam logic [7:0] EXE_MFLO_OP = 8'b00010010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } divState_e;

  // Classes 101..111 are unassigned; results of those must never reach the register file.
  function automatic logic isDefinedSel(input logic [2:0] sel);
    return (sel <= EXE_RES_ARITH);
  endfunction

endpackage

// File: rtl/stage_ex_if.sv
// Decode-to-execute bundle: operands and controls in, result, stall and HI/LO out.
interface stage_ex_if;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] opv1;
  logic [31:0] opv2;
  logic        we;
  logic [4:0]  waddr;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output aluop, alusel, opv1, opv2, we, waddr,
    input  ex_we, ex_waddr, ex_wdata, stall_req, hi, lo
  );

  modport slave (
    input  aluop, alusel, opv1, opv2, we, waddr,
    output ex_we, ex_waddr, ex_wdata, stall_req, hi, lo
  );
endinterface

// File: rtl/stage_ex_divu_iter.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, divide-by-zero
// short-circuits straight to DONE with quotient all-ones and remainder = dividend.
module divu_iter
  import stage_ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  divState_e   state_q;
  logic [4:0]  count_q;
  logic [31:0] quot_q;
  logic [31:0] rem_q;
  logic [31:0] divisor_q;
  logic        busy_q;
  logic        done_q;

  logic [32:0] shifted;
  logic [31:0] trial;
  logic        fits;

  // The shifted partial remainder can reach 33 bits; the difference always fits in 32.
  always_comb begin
    shifted = {rem_q, quot_q[31]};
    fits    = (shifted >= {1'b0, divisor_q});
    trial   = shifted[31:0] - divisor_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      count_q   <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            divisor_q <= divisor;
            count_q   <= '0;
            if (divisor == '0) begin
              quot_q  <= '1;
              rem_q   <= dividend;
              state_q <= DIV_DONE;
              done_q  <= 1'b1;
            end else begin
              quot_q  <= dividend;
              rem_q   <= '0;
              state_q <= DIV_BUSY;
              busy_q  <= 1'b1;
            end
          end
        end
        DIV_BUSY: begin
          quot_q  <= {quot_q[30:0], fits};
          rem_q   <= fits ? trial : shifted[31:0];
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_q <= DIV_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        // Always return to IDLE so a DIVU still held on the inputs cannot restart.
        DIV_DONE: begin
          state_q <= DIV_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= DIV_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: rtl/stage_ex.sv
// Execute stage: combinational ALU result toward memory/forwarding, HI/LO registers
// and the iterative DIVU unit that stalls the pipeline while it works.
module stage_ex
  import stage_ex_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  stage_ex_if.slave exBus
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        divStart;
  logic        divBusy;
  logic        divDone;
  logic [31:0] divQuot;
  logic [31:0] divRem;

  logic [4:0]  shamt;
  logic [31:0] logicRes;
  logic [31:0] shiftRes;
  logic [31:0] arithRes;
  logic [31:0] moveRes;
  logic [31:0] aluRes;

  assign divStart = (exBus.aluop == EXE_DIVU_OP);

  divu_iter uDivu (
    .clk       (clk),
    .rst       (rst),
    .start     (divStart),
    .dividend  (exBus.opv1),
    .divisor   (exBus.opv2),
    .busy      (divBusy),
    .done      (divDone),
    .quotient  (divQuot),
    .remainder (divRem)
  );

  // The issue cycle of a DIVU stalls combinationally; DONE releases the pipeline.
  assign exBus.stall_req = !rst && (divBusy || (divStart && !divDone));

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (divDone) begin
      hi_d = divRem;
      lo_d = divQuot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign shamt = exBus.opv1[4:0];

  always_comb begin
    logicRes = '0;
    case (exBus.aluop)
      EXE_OR_OP:  logicRes = exBus.opv1 | exBus.opv2;
      EXE_AND_OP: logicRes = exBus.opv1 & exBus.opv2;
      EXE_XOR_OP: logicRes = exBus.opv1 ^ exBus.opv2;
      EXE_NOR_OP: logicRes = ~(exBus.opv1 | exBus.opv2);
      default:    logicRes = '0;
    endcase
  end

  always_comb begin
    shiftRes = '0;
    case (exBus.aluop)
      EXE_SLL_OP: shiftRes = exBus.opv2 << shamt;
      EXE_SRL_OP: shiftRes = exBus.opv2 >> shamt;
      EXE_SRA_OP: shiftRes = $signed(exBus.opv2) >>> shamt;
      default:    shiftRes = '0;
    endcase
  end

  always_comb begin
    arithRes = '0;
    case (exBus.aluop)
      EXE_ADDU_OP: arithRes = exBus.opv1 + exBus.opv2;
      EXE_SUBU_OP: arithRes = exBus.opv1 - exBus.opv2;
      EXE_SLT_OP:  arithRes = {31'd0, ($signed(exBus.opv1) < $signed(exBus.opv2))};
      default:     arithRes = '0;
    endcase
  end

  always_comb begin
    moveRes = '0;
    case (exBus.aluop)
      EXE_MFHI_OP: moveRes = hi_q;
      EXE_MFLO_OP: moveRes = lo_q;
      default:     moveRes = '0;
    endcase
  end

  always_comb begin
    aluRes = '0;
    case (exBus.alusel)
      EXE_RES_LOGIC: aluRes = logicRes;
      EXE_RES_SHIFT: aluRes = shiftRes;
      EXE_RES_ARITH: aluRes = arithRes;
      EXE_RES_MOVE:  aluRes = moveRes;
      default:       aluRes = '0;
    endcase
  end

  assign exBus.ex_we    = !rst && exBus.we && isDefinedSel(exBus.alusel);
  assign exBus.ex_waddr = rst ? 5'd0 : exBus.waddr;
  assign exBus.ex_wdata = rst ? 32'd0 : aluRes;
  assign exBus.hi       = hi_q;
  assign exBus.lo       = lo_q;

endmodule

// File: tb/tb_stage_ex.sv
// Randomized self-checking bench for stage_ex against an arithmetic reference model
// of the ALU classes and of DIVU timing and results.
module tb_stage_ex;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [31:0] modelHi;
  logic [31:0] modelLo;

  stage_ex_if exBus ();

  stage_ex dut (
    .clk   (clk),
    .rst   (rst),
    .exBus (exBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                               input logic [31:0] b, input logic w, input logic [4:0] wa);
    @(negedge clk);
    exBus.aluop  = op;
    exBus.alusel = sel;
    exBus.opv1   = a;
    exBus.opv2   = b;
    exBus.we     = w;
    exBus.waddr  = wa;
    #1;
  endtask

  function automatic logic [31:0] refData(input logic [7:0] op, input logic [2:0] sel,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] h, input logic [31:0] l);
    int s;
    s = int'(a[4:0]);
    case (sel)
      3'd1: case (op)
              8'h25: return a | b;
              8'h24: return a & b;
              8'h26: return a ^ b;
              8'h27: return ~(a | b);
              default: return 32'd0;
            endcase
      3'd2: case (op)
              8'h7C: return b << s;
              8'h02: return b >> s;
              8'h03: return (b >> s) | (b[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
              default: return 32'd0;
            endcase
      3'd4: case (op)
              8'h21: return a + b;
              8'h23: return a - b;
              8'h2A: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
              default: return 32'd0;
            endcase
      3'd3: case (op)
              8'h10: return h;
              8'h12: return l;
              default: return 32'd0;
            endcase
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkAlu(input string tag, input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] b, input logic w, input logic [4:0] wa);
    applyStimulus(op, sel, a, b, w, wa);
    checkOutput({tag, "_wdata"}, exBus.ex_wdata, refData(op, sel, a, b, modelHi, modelLo));
    checkOutput({tag, "_we"}, {31'd0, exBus.ex_we}, {31'd0, (w && sel <= 3'd4)});
    checkOutput({tag, "_waddr"}, {27'd0, exBus.ex_waddr}, {27'd0, wa});
  endtask

  task automatic runDivide(input logic [31:0] a, input logic [31:0] b);
    int stalls;
    applyStimulus(8'h1B, 3'd0, a, b, 1'b0, 5'd0);
    stalls = 0;
    while (exBus.stall_req && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    checkOutput("div_stall_cycles", stalls, (b == 0) ? 32'd1 : 32'd33);
    checkOutput("div_done_we", {31'd0, exBus.ex_we}, 32'd0);
    if (b == 0) begin
      modelLo = 32'hFFFF_FFFF;
      modelHi = a;
    end else begin
      modelLo = a / b;
      modelHi = a % b;
    end
    applyStimulus(8'h12, 3'd3, 32'd0, 32'd0, 1'b1, 5'd3);
    checkOutput("div_lo", exBus.lo, modelLo);
    checkOutput("div_hi", exBus.hi, modelHi);
    checkOutput("div_mflo", exBus.ex_wdata, modelLo);
    checkOutput("div_no_restart", {31'd0, exBus.stall_req}, 32'd0);
    applyStimulus(8'h10, 3'd3, 32'd0, 32'd0, 1'b1, 5'd4);
    checkOutput("div_mfhi", exBus.ex_wdata, modelHi);
  endtask

  initial begin
    logic [7:0]  opTable [13];
    logic [2:0]  selTable [13];
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    int          pick;

    opTable  = '{8'h25, 8'h24, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03, 8'h21, 8'h23, 8'h2A, 8'h10, 8'h12, 8'h00};
    selTable = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd4, 3'd4, 3'd4, 3'd3, 3'd3, 3'd0};
    checks   = 0;
    failures = 0;
    modelHi  = 32'd0;
    modelLo  = 32'd0;
    rst      = 1'b1;

    applyStimulus(8'h25, 3'd1, 32'h1, 32'h2, 1'b1, 5'd7);
    checkOutput("rst_ex_we", {31'd0, exBus.ex_we}, 32'd0);
    checkOutput("rst_ex_waddr", {27'd0, exBus.ex_waddr}, 32'd0);
    checkOutput("rst_ex_wdata", exBus.ex_wdata, 32'd0);
    checkOutput("rst_stall", {31'd0, exBus.stall_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h00, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("rst_hi", exBus.hi, 32'd0);
    checkOutput("rst_lo", exBus.lo, 32'd0);

    checkAlu("ori", 8'h25, 3'd1, 32'h0000_1100, 32'h0000_0011, 1'b1, 5'd5);
    checkOutput("ori_exact", exBus.ex_wdata, 32'h0000_1111);
    checkAlu("sra", 8'h03, 3'd2, 32'd4, 32'h8000_0000, 1'b1, 5'd6);
    checkOutput("sra_exact", exBus.ex_wdata, 32'hF800_0000);
    checkAlu("slt", 8'h2A, 3'd4, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd8);
    checkOutput("slt_exact", exBus.ex_wdata, 32'd1);
    checkAlu("badsel", 8'h25, 3'd7, 32'h1234, 32'h5678, 1'b1, 5'd9);
    checkOutput("badsel_we", {31'd0, exBus.ex_we}, 32'd0);

    runDivide(32'd100, 32'd7);
    checkOutput("div100_lo", exBus.lo, 32'd14);
    checkOutput("div100_hi", exBus.hi, 32'd2);
    runDivide(32'h1234, 32'd0);
    checkOutput("div0_lo", exBus.lo, 32'hFFFF_FFFF);

    // Abort a division at iteration 10, then confirm a clean restart.
    applyStimulus(8'h1B, 3'd0, 32'd100, 32'd7, 1'b0, 5'd0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    exBus.aluop = 8'h00;
    #1;
    checkOutput("abort_stall_in_rst", {31'd0, exBus.stall_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    modelHi = 32'd0;
    modelLo = 32'd0;
    checkOutput("abort_stall", {31'd0, exBus.stall_req}, 32'd0);
    checkOutput("abort_hi", exBus.hi, 32'd0);
    checkOutput("abort_lo", exBus.lo, 32'd0);
    runDivide(32'd9, 32'd3);

    for (int i = 0; i < 6; i++) begin
      pick = $urandom_range(0, 3);
      a = $urandom;
      b = (pick == 0) ? 32'd0 : (pick == 1) ? 32'($urandom_range(1, 15)) : $urandom;
      runDivide(a, b);
    end

    for (int i = 0; i < 150; i++) begin
      pick = $urandom_range(0, 15);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if (pick < 13) begin
        op  = opTable[pick];
        sel = selTable[pick];
      end else begin
        op  = 8'($urandom);
        sel = (pick == 13) ? 3'($urandom_range(1, 4)) : (pick == 14) ? 3'($urandom_range(5, 7)) : 3'd0;
      end
      if (op == 8'h1B) op = 8'h00;
      checkAlu("rand", op, sel, a, b, 1'($urandom), 5'($urandom));
      checkOutput("rand_stall", {31'd0, exBus.stall_req}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
